// File: rtl/hunter_crosshair.sv
// hunter_crosshair
//   Player crosshair for the duck hunt display path. Moves a plus-shaped
//   cursor once per frame, detects trigger edges subject to a frame-based
//   cooldown, and on request emits a 9-pixel plot sequence at either the
//   current or the last drawn position.
//
// Ports
//   CLOCK_50            system clock
//   reset               asynchronous, active-low reset
//   frame_tick          one-cycle pulse per frame
//   move_left/right/up/down  direction levels (synchronised)
//   fire                trigger level (synchronised)
//   draw_req            one-cycle pulse starting a plot sequence
//   erase               with draw_req: 1 = last drawn position, 0 = current
//   x_out, y_out, plot  pixel coordinate and valid strobe
//   busy, done          sequence in progress / one-cycle completion pulse
//   shot, shot_x/y      one-cycle shot pulse and latched centre
//   cx, cy              current crosshair centre
module hunter_crosshair #(
    parameter int unsigned X_MAX    = 159,
    parameter int unsigned Y_MAX    = 119,
    parameter int unsigned X_INIT   = 80,
    parameter int unsigned Y_INIT   = 100,
    parameter int unsigned STEP     = 1,
    parameter int unsigned COOLDOWN = 8
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       move_left,
    input  logic       move_right,
    input  logic       move_up,
    input  logic       move_down,
    input  logic       fire,
    input  logic       draw_req,
    input  logic       erase,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic       plot,
    output logic       busy,
    output logic       done,
    output logic       shot,
    output logic [7:0] shot_x,
    output logic [6:0] shot_y,
    output logic [7:0] cx,
    output logic [6:0] cy
);

    localparam int unsigned CW    = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
    localparam logic [8:0]  LO    = 9'd2;
    localparam logic [8:0]  STEP9 = 9'(STEP);
    localparam logic [8:0]  X_HI  = 9'(X_MAX - 2);
    localparam logic [8:0]  Y_HI  = 9'(Y_MAX - 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLOT,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      idx_q, idx_d;
    logic [7:0]      cx_q, cx_d;
    logic [6:0]      cy_q, cy_d;
    logic [7:0]      last_x_q, last_x_d;
    logic [6:0]      last_y_q, last_y_d;
    logic [7:0]      snap_x_q, snap_x_d;
    logic [6:0]      snap_y_q, snap_y_d;
    logic [CW-1:0]   cool_q, cool_d;
    logic            fire_prev_q;
    logic            shot_q, shot_d;
    logic [7:0]      shot_x_q, shot_x_d;
    logic [6:0]      shot_y_q, shot_y_d;
    logic [7:0]      x_out_q, x_out_d;
    logic [6:0]      y_out_q, y_out_d;
    logic            plot_q, plot_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            fire_edge;

    // One clamped step on a single axis. Widened to 9 bits so a decrement
    // near zero is caught by the compare instead of wrapping.
    function automatic logic [7:0] step_axis(input logic [7:0] p, input logic dec,
                                             input logic inc, input logic [8:0] hi);
        logic [8:0] w;
        w = {1'b0, p};
        if (dec && !inc)
            step_axis = (w < LO + STEP9) ? 8'(LO) : 8'(w - STEP9);
        else if (inc && !dec)
            step_axis = (w + STEP9 > hi) ? 8'(hi) : 8'(w + STEP9);
        else
            step_axis = p;
    endfunction

    // Sprite pixel i around (x,y): centre, horizontal arm, vertical arm.
    function automatic logic [14:0] pixel(input logic [3:0] i, input logic [7:0] x,
                                          input logic [6:0] y);
        logic [7:0] px;
        logic [6:0] py;
        px = x;
        py = y;
        case (i)
            4'd1: px = x - 8'd2;
            4'd2: px = x - 8'd1;
            4'd3: px = x + 8'd1;
            4'd4: px = x + 8'd2;
            4'd5: py = y - 7'd2;
            4'd6: py = y - 7'd1;
            4'd7: py = y + 7'd1;
            4'd8: py = y + 7'd2;
            default: ;
        endcase
        pixel = {px, py};
    endfunction

    // Movement
    always_comb begin
        cx_d = cx_q;
        cy_d = cy_q;
        if (frame_tick) begin
            cx_d = step_axis(cx_q, move_left, move_right, X_HI);
            cy_d = 7'(step_axis({1'b0, cy_q}, move_up, move_down, Y_HI));
        end
    end

    // Trigger: a shot reloads the cooldown, which takes priority over the
    // per-frame decrement in the same cycle.
    assign fire_edge = fire && !fire_prev_q;

    always_comb begin
        shot_d   = 1'b0;
        shot_x_d = shot_x_q;
        shot_y_d = shot_y_q;
        cool_d   = cool_q;
        if (fire_edge && cool_q == '0) begin
            shot_d   = 1'b1;
            shot_x_d = cx_q;
            shot_y_d = cy_q;
            cool_d   = CW'(COOLDOWN);
        end else if (frame_tick && cool_q != '0) begin
            cool_d = cool_q - 1'b1;
        end
    end

    // Plot sequencer. Outputs are computed one cycle ahead so the pixel
    // for idx is on x_out/y_out while idx_q holds that value.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        snap_x_d = snap_x_q;
        snap_y_d = snap_y_q;
        last_x_d = last_x_q;
        last_y_d = last_y_q;
        x_out_d  = x_out_q;
        y_out_d  = y_out_q;
        plot_d   = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (draw_req) begin
                    if (erase) begin
                        snap_x_d = last_x_q;
                        snap_y_d = last_y_q;
                    end else begin
                        snap_x_d = cx_q;
                        snap_y_d = cy_q;
                        last_x_d = cx_q;
                        last_y_d = cy_q;
                    end
                    state_d            = S_PLOT;
                    idx_d              = 4'd0;
                    {x_out_d, y_out_d} = pixel(4'd0, snap_x_d, snap_y_d);
                    plot_d             = 1'b1;
                    busy_d             = 1'b1;
                end
            end
            S_PLOT: begin
                busy_d = 1'b1;
                if (idx_q == 4'd8) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    idx_d              = idx_q + 4'd1;
                    {x_out_d, y_out_d} = pixel(idx_d, snap_x_q, snap_y_q);
                    plot_d             = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            cx_q        <= 8'(X_INIT);
            cy_q        <= 7'(Y_INIT);
            last_x_q    <= 8'(X_INIT);
            last_y_q    <= 7'(Y_INIT);
            snap_x_q    <= '0;
            snap_y_q    <= '0;
            cool_q      <= '0;
            fire_prev_q <= 1'b0;
            shot_q      <= 1'b0;
            shot_x_q    <= '0;
            shot_y_q    <= '0;
            x_out_q     <= '0;
            y_out_q     <= '0;
            plot_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            last_x_q    <= last_x_d;
            last_y_q    <= last_y_d;
            snap_x_q    <= snap_x_d;
            snap_y_q    <= snap_y_d;
            cool_q      <= cool_d;
            fire_prev_q <= fire;
            shot_q      <= shot_d;
            shot_x_q    <= shot_x_d;
            shot_y_q    <= shot_y_d;
            x_out_q     <= x_out_d;
            y_out_q     <= y_out_d;
            plot_q      <= plot_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign x_out  = x_out_q;
    assign y_out  = y_out_q;
    assign plot   = plot_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign shot   = shot_q;
    assign shot_x = shot_x_q;
    assign shot_y = shot_y_q;
    assign cx     = cx_q;
    assign cy     = cy_q;

endmodule
